// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//
// Parameterised register file with two combinational read ports, one write
// port, and a start-up clear sequencer. After reset is released, the
// sequencer writes zero to every entry, one entry per cycle, and then enters
// READY. In READY the write port is open. While clearing, writes are
// discarded and flagged with a one-cycle wr_drop pulse, and both read ports
// return zero.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    address width; the file holds 2**ADDR_W entries
//   ZERO_REG  when nonzero, entry 0 always reads 0 and silently ignores writes
//
// Optional feature
//   RF_BYPASS_EN  when this macro is defined, a write in READY is forwarded to
//                 any read port that addresses the same entry in the same
//                 cycle. When it is undefined, reads see only stored contents.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      synchronous, active-low reset; restarts the clear sequence
//   rd_addr_1  read port 1 address
//   rd_data_1  read port 1 data (combinational)
//   rd_addr_2  read port 2 address
//   rd_data_2  read port 2 data (combinational)
//   we         write enable
//   wr_addr    write address
//   wr_data    write data
//   ready      high once every entry has been cleared and writes are accepted
//   wr_drop    registered one-cycle pulse: a write arrived while clearing
// ---------------------------------------------------------------------------
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ready,
  output logic              wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_next;
  logic              drop_next;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_hits_zero;

  // A write to the hardwired zero entry is swallowed with no drop indication.
  assign wr_hits_zero = (ZERO_REG != 0) && (wr_addr == '0);

  assign ready = (state == READY);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
      wr_drop <= drop_next;
    end
  end

  // The single array write port is shared. The sequencer owns it while
  // clearing and the external write port owns it in READY.
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    drop_next    = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = wr_addr;
    mem_data     = wr_data;
    case (state)
      CLEAR: begin
        mem_we       = 1'b1;
        mem_addr     = clr_ptr;
        mem_data     = '0;
        drop_next    = we;
        // The pointer wraps to 0 naturally when the last entry is cleared.
        clr_ptr_next = clr_ptr + 1'b1;
        if (clr_ptr == {ADDR_W{1'b1}}) begin
          state_next = READY;
        end
      end
      READY: begin
        mem_we = we && !wr_hits_zero;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  // The array has no reset. Writes are blocked while reset is held, so a
  // write presented during reset is neither stored nor flagged.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[mem_addr] <= mem_data;
    end
  end

  always_comb begin
    rd_data_1 = mem[rd_addr_1];
    if (state != READY) begin
      rd_data_1 = '0;
    end else if ((ZERO_REG != 0) && (rd_addr_1 == '0)) begin
      rd_data_1 = '0;
    end else if (BYPASS && we && !wr_hits_zero && (wr_addr == rd_addr_1)) begin
      rd_data_1 = wr_data;
    end
  end

  always_comb begin
    rd_data_2 = mem[rd_addr_2];
    if (state != READY) begin
      rd_data_2 = '0;
    end else if ((ZERO_REG != 0) && (rd_addr_2 == '0)) begin
      rd_data_2 = '0;
    end else if (BYPASS && we && !wr_hits_zero && (wr_addr == rd_addr_2)) begin
      rd_data_2 = wr_data;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
//
// Self-checking bench for regfile_param with default parameters (32 x 32,
// ZERO_REG=1). Inputs are driven 1 time unit after each rising edge.
// Combinational reads are sampled on the falling edge, and registered
// outputs are sampled 1 unit after the rising edge. The reference model
// tracks how many clear cycles have elapsed and holds the register contents
// in a plain array. Forwarding expectations follow RF_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_regfile_param;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic [DATA_W-1:0] rd_data_1;
  logic [DATA_W-1:0] rd_data_2;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ready;
  logic              wr_drop;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                model_clear_count = 0;
  logic              model_is_ready    = 1'b0;
  logic              model_drop        = 1'b0;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [DATA_W-1:0] e1;
    logic [DATA_W-1:0] e2;
    logic              edrop;
  } vec_t;

  vec_t vecs [10];

  regfile_param #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr_1(rd_addr_1),
    .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1),
    .rd_data_2(rd_data_2),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ready    (ready),
    .wr_drop  (wr_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // The file reads zero until all entries are cleared. Entry 0 always reads
  // zero. Otherwise a read returns the forwarded write data when bypassing,
  // or the stored value.
  function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (!model_is_ready) return '0;
    if (a == '0) return '0;
    if (BYP && we && (wr_addr == a)) return wr_data;
    return model_mem[a];
  endfunction

  // Advances the model by one rising edge, using the inputs that were present
  // at that edge.
  task automatic model_update();
    if (!reset) begin
      model_clear_count = 0;
      model_is_ready    = 1'b0;
      model_drop        = 1'b0;
    end else if (!model_is_ready) begin
      model_drop        = we;
      model_clear_count = model_clear_count + 1;
      if (model_clear_count == DEPTH) begin
        model_is_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      end
    end else begin
      model_drop = 1'b0;
      if (we && (wr_addr != '0)) model_mem[wr_addr] = wr_data;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic w,
                               input logic [ADDR_W-1:0] wa,
                               input logic [DATA_W-1:0] wd,
                               input logic [ADDR_W-1:0] a1,
                               input logic [ADDR_W-1:0] a2);
    reset     = r;
    we        = w;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr_1 = a1;
    rd_addr_2 = a2;
  endtask

  task automatic checkOutput(input string name,
                             input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Runs one full clear sequence after reset has been released. When drop_at
  // is non-negative, a write to r5 is presented at that clear cycle.
  task automatic run_clear(input int drop_at);
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b1, (k == drop_at), 5'd5, 32'hCAFE0005,
                    5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
      @(negedge clk);
      checkOutput("clear_ready", 32'(ready), 32'd0);
      checkOutput("clear_rd1", rd_data_1, 32'd0);
      checkOutput("clear_rd2", rd_data_2, 32'd0);
      step();
      if (k == drop_at) checkOutput("clear_drop_pulse", 32'(wr_drop), 32'd1);
      else              checkOutput("clear_drop_idle", 32'(wr_drop), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    checkOutput("ready_after_clear", 32'(ready), 32'd1);
    checkOutput("drop_after_clear", 32'(wr_drop), 32'd0);
  endtask

  initial begin
    logic              r;
    logic              w;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [DATA_W-1:0] wd;

    // Directed vectors applied back to back, starting from an all-zero file.
    vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd7,
                BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 1'b0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,
                32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,
                32'h0, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd7,
                32'h0, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd7,
                BYP ? 32'hA5A5A5A5 : 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,
                32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    vecs[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd3,
                BYP ? 32'hFFFFFFFF : 32'h0, 32'hA5A5A5A5, 1'b0};
    vecs[7] = '{1'b1, 5'd3,  32'h11111111, 5'd31, 5'd3,
                32'hFFFFFFFF, BYP ? 32'h11111111 : 32'hA5A5A5A5, 1'b0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd31,
                32'h11111111, 32'hFFFFFFFF, 1'b0};
    vecs[9] = '{1'b1, 5'd9,  32'h00000055, 5'd9,  5'd1,
                BYP ? 32'h00000055 : 32'h0, 32'h0, 1'b0};

    // Reset, with a write presented that must be ignored.
    applyStimulus(1'b0, 1'b1, 5'd4, 32'h0BADF00D, 5'd0, 5'd0);
    step();
    step();
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_drop", 32'(wr_drop), 32'd0);

    // Clear sequence with a dropped write to r5 at clear cycle 10.
    run_clear(10);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    @(negedge clk);
    checkOutput("r5_after_drop_p1", rd_data_1, 32'd0);
    checkOutput("r5_after_drop_p2", rd_data_2, 32'd0);
    step();

    // Directed vectors in READY.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].a1, vecs[i].a2);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rd1", i), rd_data_1, vecs[i].e1);
      checkOutput($sformatf("vec%0d_rd2", i), rd_data_2, vecs[i].e2);
      step();
      checkOutput($sformatf("vec%0d_drop", i), 32'(wr_drop), 32'(vecs[i].edrop));
      checkOutput($sformatf("vec%0d_ready", i), 32'(ready), 32'd1);
    end

    // r9 holds 0x55. After a one-cycle reset pulse it must be cleared again.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    @(negedge clk);
    checkOutput("r9_before_reset", rd_data_1, 32'h55);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    step();
    checkOutput("pulse_reset_ready", 32'(ready), 32'd0);
    checkOutput("pulse_reset_drop", 32'(wr_drop), 32'd0);
    run_clear(-1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    @(negedge clk);
    checkOutput("r9_after_reclear_p1", rd_data_1, 32'd0);
    checkOutput("r9_after_reclear_p2", rd_data_2, 32'd0);
    step();

    // Randomized traffic against the reference model, including occasional resets.
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(63, 0) != 0);
      w = 1'($urandom_range(1, 0));
      case ($urandom_range(3, 0))
        0:       wa = 5'd0;
        1:       wa = 5'd3;
        default: wa = 5'($urandom_range(31, 0));
      endcase
      wd = $urandom;
      a1 = ($urandom_range(1, 0) != 0) ? wa : 5'($urandom_range(31, 0));
      a2 = ($urandom_range(1, 0) != 0) ? wa : 5'($urandom_range(31, 0));
      applyStimulus(r, w, wa, wd, a1, a2);
      @(negedge clk);
      checkOutput("rand_rd1", rd_data_1, model_read(rd_addr_1));
      checkOutput("rand_rd2", rd_data_2, model_read(rd_addr_2));
      checkOutput("rand_ready", 32'(ready), 32'(model_is_ready));
      step();
      checkOutput("rand_drop", 32'(wr_drop), 32'(model_drop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL provide parameter ZERO_REG, default 1, entry 0 hardwired to zero when 1.
REQ-004 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL provide port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL provide port rd_addr_1  input  ADDR_W  read port 1 address.
REQ-007 SHALL provide port rd_addr_2  input  ADDR_W  read port 2 address.
REQ-008 SHALL provide port rd_data_1  output  DATA_W  read port 1 data, combinational from array/bypass.
REQ-009 SHALL provide port rd_data_2  output  DATA_W  read port 2 data, combinational from array/bypass.
REQ-010 SHALL provide port we  input  1  write enable (writeback stage).
REQ-011 SHALL provide port wr_addr  input  ADDR_W  write address.
REQ-012 SHALL provide port wr_data  input  DATA_W  write data.
REQ-013 SHALL provide port ready  output  1  high when array initialised and accepting writes.
REQ-014 SHALL provide port wr_drop  output  1  registered one-cycle pulse: a write was discarded while not ready.

Function
REQ-015 SHALL implement a clear sequencer with states CLEAR and READY.
REQ-016 In CLEAR, SHALL write zero to entry clr_ptr each cycle and increment clr_ptr by 1.
REQ-017 SHALL go CLEAR -> READY on the cycle clr_ptr == DEPTH-1 is cleared; clear takes exactly DEPTH cycles after reset deasserts.
REQ-018 SHALL hold READY until reset; READY has no exit other than reset.
REQ-019 ready SHALL be 1 only in READY, asserted from the cycle after the last entry clear.
REQ-020 In READY, with we=1, SHALL store wr_data into entry wr_addr on the rising clk edge; visible on reads the following cycle.
REQ-021 In CLEAR, SHALL discard any write and assert wr_drop for one cycle on the next clock edge.
REQ-022 In CLEAR, rd_data_1 and rd_data_2 SHALL read 0 regardless of address.
REQ-023 With ZERO_REG=1, writes to entry 0 SHALL be discarded silently (no wr_drop), and reads of entry 0 SHALL return 0.
REQ-024 With ZERO_REG=0, entry 0 SHALL behave as an ordinary register.
REQ-025 Both read ports SHALL operate independently; equal addresses return identical data.
REQ-026 clr_ptr SHALL be ADDR_W bits and wrap to 0 on the CLEAR->READY transition.

Reset
REQ-027 While reset=0 at a clock edge, SHALL set state=CLEAR, clr_ptr=0, ready=0, wr_drop=0.
REQ-028 Reset asserted mid-clear or in READY SHALL restart the sequencer from entry 0; array contents are undefined until re-cleared.
REQ-029 Writes presented while reset=0 SHALL be ignored without wr_drop.

Configuration
REQ-030 Macro RF_BYPASS_EN SHALL control write-to-read forwarding.
REQ-031 With RF_BYPASS_EN defined, in READY, when we=1 and wr_addr equals a read address (and not entry 0 with ZERO_REG=1), that port SHALL return wr_data in the same cycle.
REQ-032 Without RF_BYPASS_EN, reads SHALL return only stored array contents; a same-cycle write is visible the next cycle.

Verification
REQ-033 Release reset, sample ready -> ready=0 for exactly 32 cycles (ADDR_W=5), then 1; every read returns 0.
REQ-034 In READY write 0xDEADBEEF to r7, then read r7 on both ports -> 0xDEADBEEF on both the next cycle.
REQ-035 Write 0x12345678 to r0 (ZERO_REG=1) -> rd_data of r0 stays 0x00000000, wr_drop stays 0.
REQ-036 we=1, wr_addr=3, wr_data=0xA5A5A5A5, rd_addr_1=3 same cycle -> rd_data_1=0xA5A5A5A5 same cycle with RF_BYPASS_EN, old value (0) without.
REQ-037 Assert we to r5 at clear cycle 10 -> wr_drop=1 for one cycle, r5 reads 0 after ready.
REQ-038 Write r9=0x55 in READY, pulse reset low one cycle -> ready=0 for 32 cycles, r9 then reads 0.
